uart_stream_emitter: RTL and testbench

UART_STREAM_EMITTER -- requirements
Module: uart_stream_emitter

---
 rtl/uart_stream_emitter.sv | 217 +++++++++++++++++++++
 tb/tb_uart_stream_emitter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_emitter.sv
// uart_stream_emitter: byte-stream FIFO feeding a UART transmitter with optional
// parity, one or two stop bits, and an optional end-of-line frame after tlast beats.
module uart_stream_emitter #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         DATA_BITS    = 8,
  parameter int         PARITY       = 0,
  parameter int         STOP_BITS    = 1,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         APPEND_EOL   = 0,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [7:0]                          i_tdata,
  input  logic                                i_tlast,
  input  logic                                i_tvalid,
  output logic                                o_tready,
  output logic                                o_uart_tx,
  output logic                                o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);

  localparam logic [7:0]    DATA_MASK = 8'hFF >> (8 - DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          EOL_EN    = (APPEND_EOL != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          run_q;
  logic          full, empty, push, pop;
  logic [8:0]    head;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign o_tready = run_q & ~full;
  assign push     = i_tvalid & o_tready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem_q[wr_ptr_q] <= {i_tlast, i_tdata};
  end

  // ---------------------------------------------------------------- transmitter
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          eol_q, eol_d;
  logic          load_en;
  logic [7:0]    load_byte;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_d      = tx_q;
    eol_d     = eol_q;
    pop       = 1'b0;
    load_en   = 1'b0;
    load_byte = 8'h00;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          load_en   = 1'b1;
          load_byte = head[7:0];
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = BIT_LAST;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (idx_q == IDX_LAST) begin
            if (HAS_PAR) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              cnt_d   = STOP_LAST;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          cnt_d   = STOP_LAST;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        // all stop bits share one timer; a pending EOL wins over queued data
        if (cnt_q == '0) begin
          if (eol_q) begin
            eol_d     = 1'b0;
            load_en   = 1'b1;
            load_byte = EOL_CHAR;
          end else if (!empty) begin
            pop       = 1'b1;
            load_en   = 1'b1;
            load_byte = head[7:0];
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load_en) begin
      state_d = ST_START;
      cnt_d   = BIT_LAST;
      idx_d   = '0;
      tx_d    = 1'b0;
      shreg_d = load_byte & DATA_MASK;
      par_d   = (^(load_byte & DATA_MASK)) ^ PAR_ODD;
    end

    if (pop && EOL_EN && head[8]) eol_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      run_q    <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      eol_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      run_q    <= 1'b1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      eol_q    <= eol_d;
    end
  end

  assign o_uart_tx    = tx_q;
  assign o_fifo_level = level_q;
  assign o_busy       = (state_q != ST_IDLE) | ~empty | eol_q;

endmodule

// File: tb/tb_uart_stream_emitter.sv
// Directed bench for uart_stream_emitter: four instances cover 8N1, even/odd
// parity with two stop bits, FIFO backpressure, EOL insertion and mid-frame reset.
module tb_uart_stream_emitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tlast;
  logic       a_valid, e_valid, o_valid, l_valid;
  logic       a_ready, e_ready, o_ready, l_ready;
  logic       a_tx, e_tx, o_tx, l_tx;
  logic       a_busy, e_busy, o_busy, l_busy;
  logic [2:0] a_level;
  logic [4:0] e_level, o_level, l_level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_stream_emitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                        .FIFO_DEPTH(4), .APPEND_EOL(0), .EOL_CHAR(8'h0A)) u_a (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(a_valid),
    .o_tready(a_ready), .o_uart_tx(a_tx), .o_busy(a_busy), .o_fifo_level(a_level));

  uart_stream_emitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                        .FIFO_DEPTH(16), .APPEND_EOL(0), .EOL_CHAR(8'h0A)) u_e (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(e_valid),
    .o_tready(e_ready), .o_uart_tx(e_tx), .o_busy(e_busy), .o_fifo_level(e_level));

  uart_stream_emitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                        .FIFO_DEPTH(16), .APPEND_EOL(0), .EOL_CHAR(8'h0A)) u_o (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(o_valid),
    .o_tready(o_ready), .o_uart_tx(o_tx), .o_busy(o_busy), .o_fifo_level(o_level));

  uart_stream_emitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                        .FIFO_DEPTH(16), .APPEND_EOL(1), .EOL_CHAR(8'h0A)) u_l (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(l_valid),
    .o_tready(l_ready), .o_uart_tx(l_tx), .o_busy(l_busy), .o_fifo_level(l_level));

  function automatic logic tx_of(input int w);
    case (w)
      0:       return a_tx;
      1:       return e_tx;
      2:       return o_tx;
      default: return l_tx;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return a_busy;
      1:       return e_busy;
      2:       return o_busy;
      default: return l_busy;
    endcase
  endfunction

  // expected line level s cycles into a frame at 4 clocks per bit; stop/idle is 1
  function automatic logic exp_bit(input int s, input logic [7:0] d, input bit has_par,
                                   input logic p);
    int b;
    b = s / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (has_par && b == 9) return p;
    return 1'b1;
  endfunction

  task automatic capture(input int w, input int n, input bit wait_first, output bit ok,
                         output logic [319:0] v, output logic [319:0] bz);
    int s0;
    v  = '1;
    bz = '0;
    ok = 1'b1;
    s0 = 0;
    if (wait_first) begin
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (tx_of(w) === 1'b0) begin
          ok = 1'b1;
          break;
        end
      end
      if (ok) begin
        v[0]  = 1'b0;
        bz[0] = busy_of(w);
        s0    = 1;
      end
    end
    if (ok) begin
      for (int s = s0; s < n; s++) begin
        @(negedge clk);
        v[s]  = tx_of(w);
        bz[s] = busy_of(w);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", a_ready); end
    checks++;
    if (a_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", a_tx); end
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++;
    if ({a_level, e_level, o_level, l_level} !== 18'd0) begin
      failures++;
      $display("FAIL reset_level got=%0d/%0d/%0d/%0d exp=0", a_level, e_level, o_level, l_level);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ready, e_ready, o_ready, l_ready} !== 4'b1111) begin
      failures++;
      $display("FAIL release_tready got=%b exp=1111", {a_ready, e_ready, o_ready, l_ready});
    end
  endtask

  task automatic test_frame_8n1();
    logic [319:0] v, bz;
    bit ok;
    int bad;
    @(negedge clk);
    tdata = 8'h55; tlast = 1'b0; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_level !== 3'd1) begin
      failures++;
      $display("FAIL queued_55 busy=%b level=%0d exp busy=1 level=1", a_busy, a_level);
    end
    capture(0, 41, 1'b0, ok, v, bz);
    bad = 0;
    for (int s = 0; s < 40; s++) if (v[s] !== exp_bit(s, 8'h55, 1'b0, 1'b0)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL frame_55_shape bad_cycles=%0d exp=0", bad); end
    checks++;
    if (bz[39] !== 1'b1 || bz[40] !== 1'b0 || v[40] !== 1'b1) begin
      failures++;
      $display("FAIL frame_55_end busy39=%b busy40=%b tx40=%b exp 1/0/1", bz[39], bz[40], v[40]);
    end
  endtask

  task automatic test_parity();
    logic [319:0] ve, be, vo, bo;
    bit oke, oko;
    int bad_e, bad_o;
    @(negedge clk);
    tdata = 8'h07; tlast = 1'b0; e_valid = 1'b1; o_valid = 1'b1;
    @(negedge clk);
    e_valid = 1'b0; o_valid = 1'b0;
    fork
      capture(1, 49, 1'b0, oke, ve, be);
      capture(2, 49, 1'b0, oko, vo, bo);
    join
    bad_e = 0;
    bad_o = 0;
    for (int s = 0; s < 44; s++) if (ve[s] !== exp_bit(s, 8'h07, 1'b1, 1'b1)) bad_e++;
    for (int s = 0; s < 48; s++) if (vo[s] !== exp_bit(s, 8'h07, 1'b1, 1'b0)) bad_o++;
    checks++;
    if (ve[38] !== 1'b1) begin failures++; $display("FAIL even_parity_bit got=%b exp=1", ve[38]); end
    checks++;
    if (bad_e != 0) begin failures++; $display("FAIL even_frame_shape bad_cycles=%0d exp=0", bad_e); end
    checks++;
    if (be[43] !== 1'b1 || be[44] !== 1'b0) begin
      failures++;
      $display("FAIL even_frame_len busy43=%b busy44=%b exp 1/0", be[43], be[44]);
    end
    checks++;
    if (vo[38] !== 1'b0) begin failures++; $display("FAIL odd_parity_bit got=%b exp=0", vo[38]); end
    checks++;
    if (bad_o != 0) begin failures++; $display("FAIL odd_frame_shape bad_cycles=%0d exp=0", bad_o); end
    checks++;
    if (vo[47:40] !== 8'hFF || bo[47] !== 1'b1 || bo[48] !== 1'b0) begin
      failures++;
      $display("FAIL two_stop_bits tx=%h busy47=%b busy48=%b exp ff/1/0", vo[47:40], bo[47], bo[48]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]   beats [6];
    logic [319:0] v, bz;
    bit ok;
    int idx, fall, maxlvl, bad;
    bit hs;
    beats = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    @(negedge clk);
    rst = 1'b1; tlast = 1'b0; tdata = beats[0]; a_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idx = 0; fall = -1; maxlvl = 0; hs = 1'b0;
    fork
      begin
        for (int c = 0; c < 400 && idx < 6; c++) begin
          @(negedge clk);
          if (hs) begin
            idx++;
            if (idx == 6) a_valid = 1'b0;
            else tdata = beats[idx];
          end
          if (idx < 6) begin
            if (int'(a_level) > maxlvl) maxlvl = int'(a_level);
            if (!a_ready && fall < 0) fall = idx;
            hs = a_ready;
          end
        end
        a_valid = 1'b0;
      end
      capture(0, 241, 1'b1, ok, v, bz);
    join
    checks++;
    if (fall != 5) begin failures++; $display("FAIL accepted_before_full got=%0d exp=5", fall); end
    checks++;
    if (maxlvl != 4) begin failures++; $display("FAIL max_fifo_level got=%0d exp=4", maxlvl); end
    checks++;
    if (idx != 6) begin failures++; $display("FAIL all_beats_accepted got=%0d exp=6", idx); end
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_start_timeout got=0 exp=1"); end
    for (int f = 0; f < 6; f++) begin
      bad = 0;
      for (int s = 0; s < 40; s++) if (v[f*40+s] !== exp_bit(s, beats[f], 1'b0, 1'b0)) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL b2b_frame%0d bad_cycles=%0d exp=0 byte=%h", f, bad, beats[f]);
      end
    end
    checks++;
    if (bz[239] !== 1'b1 || bz[240] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy_end busy239=%b busy240=%b exp 1/0", bz[239], bz[240]);
    end
  endtask

  task automatic test_eol();
    logic [7:0]   exp_bytes [4];
    logic [319:0] v, bz;
    bit ok;
    int bad;
    exp_bytes = '{8'h41, 8'h42, 8'h0A, 8'h43};
    fork
      begin
        @(negedge clk); tdata = 8'h41; tlast = 1'b0; l_valid = 1'b1;
        @(negedge clk); tdata = 8'h42; tlast = 1'b1;
        @(negedge clk); tdata = 8'h43; tlast = 1'b0;
        @(negedge clk); l_valid = 1'b0;
      end
      capture(3, 161, 1'b1, ok, v, bz);
    join
    checks++;
    if (!ok) begin failures++; $display("FAIL eol_start_timeout got=0 exp=1"); end
    for (int f = 0; f < 4; f++) begin
      bad = 0;
      for (int s = 0; s < 40; s++) if (v[f*40+s] !== exp_bit(s, exp_bytes[f], 1'b0, 1'b0)) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL eol_frame%0d bad_cycles=%0d exp=0 byte=%h", f, bad, exp_bytes[f]);
      end
    end
    checks++;
    if (bz[159] !== 1'b1 || bz[160] !== 1'b0) begin
      failures++;
      $display("FAIL eol_busy_end busy159=%b busy160=%b exp 1/0", bz[159], bz[160]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [319:0] v, bz;
    bit ok;
    int bad;
    @(negedge clk); tdata = 8'h3A; tlast = 1'b0; a_valid = 1'b1;
    @(negedge clk); tdata = 8'h11;
    @(negedge clk); tdata = 8'h22;
    @(negedge clk); tdata = 8'h33;
    @(negedge clk); a_valid = 1'b0;
    checks++;
    if (a_level !== 3'd3) begin failures++; $display("FAIL midframe_level got=%0d exp=3", a_level); end
    repeat (12) @(negedge clk);
    checks++;
    if (a_tx !== 1'b0) begin failures++; $display("FAIL midframe_data_bit2 got=%b exp=0", a_tx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (a_tx !== 1'b1 || a_level !== 3'd0 || a_busy !== 1'b0 || a_ready !== 1'b0) begin
      failures++;
      $display("FAIL after_pulse tx=%b level=%0d busy=%b tready=%b exp 1/0/0/0",
               a_tx, a_level, a_busy, a_ready);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_level !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL quiet_after_reset bad_cycles=%0d exp=0", bad); end
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL tready_after_pulse got=%b exp=1", a_ready); end
    fork
      begin
        tdata = 8'h5A; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
      end
      capture(0, 40, 1'b1, ok, v, bz);
    join
    bad = 0;
    for (int s = 0; s < 40; s++) if (v[s] !== exp_bit(s, 8'h5A, 1'b0, 1'b0)) bad++;
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL recovery_frame started=%0d bad_cycles=%0d exp 1/0", ok, bad);
    end
  endtask

  initial begin
    rst = 1'b1; tdata = 8'h00; tlast = 1'b0;
    a_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; l_valid = 1'b0;
    test_reset();
    test_frame_8n1();
    test_parity();
    test_back_to_back();
    test_eol();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time_ns=%0t limit=1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
